pm_result_display: RTL and testbench

- Downstream output stage of the processor top. Consumes the three 4-bit result registers r0, r1, r2 and drives a 4-digit, common-anode, multiplexed seven-segment display on the board.
- Captures the results once per scan frame, so a digit never shows a mix of old and new values within a frame.
- Scans the digits with a refresh counter and a 4-state digit FSM.
- Applies a short ghost-suppression blanking interval at the start of each digit slot.

---
 rtl/pm_disp_pkg.sv | 35 +++
 rtl/pm_hex7seg.sv | 11 +
 rtl/pm_result_display.sv | 115 +++++++++++
 tb/tb_pm_result_display.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pm_disp_pkg.sv
// Shared types and constants for the result display: digit-slot states,
// inactive drive levels and the active-low hex-to-segment table (gfedcba).
package pm_disp_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Entry i holds the pattern for nibble value i; listed from F down to 0.
    localparam logic [15:0][6:0] HEX7_TBL = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/pm_hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder (gfedcba).
module pm_hex7seg
    import pm_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_TBL[nibble];

endmodule

// File: rtl/pm_result_display.sv
// Four-digit multiplexed seven-segment driver for results r0..r2, snapshot once per frame.
// Optional leading-zero blanking of digits 2/1 when PM_LZ_BLANK_EN is defined.
//
// state | meaning
// DIG0  | slot driving digit 0 (r0 snapshot); frame starts at cnt==0 here
// DIG1  | slot driving digit 1 (r1 snapshot)
// DIG2  | slot driving digit 2 (r2 snapshot)
// DIG3  | idle slot, all anodes off, keeps 1/4 duty per digit
module pm_result_display
    import pm_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4,
    parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [3:0] r0,
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    dig_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       snap0, snap1, snap2;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;
    logic             frame_start;
    logic             blank_win;
    logic             lz_blank;

    assign frame_start = (state == DIG0) && (cnt == '0);
    assign blank_win   = (cnt < BLANK_LIM);

    always_comb begin
        nib = snap2;
        case (state)
            DIG0:    nib = snap0;
            DIG1:    nib = snap1;
            default: nib = snap2;
        endcase
    end

    pm_hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg_dec)
    );

    // Leading-zero decision uses the frame snapshot, so it is stable within a frame.
    always_comb begin
        lz_blank = 1'b0;
`ifdef PM_LZ_BLANK_EN
        if (state == DIG2)
            lz_blank = (snap2 == 4'd0);
        else if (state == DIG1)
            lz_blank = (snap2 == 4'd0) && (snap1 == 4'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            state <= DIG0;
            snap0 <= 4'd0;
            snap1 <= 4'd0;
            snap2 <= 4'd0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                case (state)
                    DIG0:    state <= DIG1;
                    DIG1:    state <= DIG2;
                    DIG2:    state <= DIG3;
                    default: state <= DIG0;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame <= frame_start;
            dp    <= 1'b1;

            if (frame_start && !hold) begin
                snap0 <= r0;
                snap1 <= r1;
                snap2 <= r2;
            end

            if (blank_win || state == DIG3) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                case (state)
                    DIG0:    an <= 4'b1110;
                    DIG1:    an <= 4'b1101;
                    default: an <= 4'b1011;
                endcase
                seg <= lz_blank ? SEG_BLANK : seg_dec;
            end
        end
    end

endmodule

// File: tb/tb_pm_result_display.sv
// Bench for pm_result_display with REFRESH_DIV=8, BLANK_CYC=2: cycle-indexed
// reference model plus literal expectations for the directed scenarios.
module tb_pm_result_display;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic [3:0] r0 = 4'd0, r1 = 4'd0, r2 = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    pm_result_display #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .r0    (r0),
        .r1    (r1),
        .r2    (r2),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .frame (frame)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int scen  = 0;

    // Model: k is the index of the current cycle since reset release.
    int         k = 0;
    bit         model_ok = 0;
    bit         rst_seen = 0;
    logic [3:0] m_snap [3];
    logic [3:0] e_an  = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_frame = 1'b0;

`ifdef PM_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    always @(posedge clk) begin
        int slot, pos;
        bit lzb;
        if (reset) begin
            k = 0;
            for (int i = 0; i < 3; i++) m_snap[i] = 4'd0;
            e_an = 4'hF; e_seg = 7'h7F; e_frame = 1'b0;
            rst_seen = 1;
        end else begin
            slot = (k / RD) % 4;
            pos  = k % RD;
            e_frame = (k % (4 * RD) == 0);
            if (pos < BC || slot == 3) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                e_an = 4'(~(4'b0001 << slot));
                lzb = LZ && ((slot == 2 && m_snap[2] == 0) ||
                             (slot == 1 && m_snap[2] == 0 && m_snap[1] == 0));
                e_seg = lzb ? 7'h7F : hex_ref(m_snap[slot]);
            end
            if (k % (4 * RD) == 0 && !hold) begin
                m_snap[0] = r0; m_snap[1] = r1; m_snap[2] = r2;
            end
            rst_seen = 0;
            k++;
        end
        model_ok = 1;
    end

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d (scen %0d): got %b expected %b", name, k, scen, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_an", 7'(an), 7'(e_an));
            chk("model_seg", seg, e_seg);
            chk("model_dp", 7'(dp), 7'd1);
            chk("model_frame", 7'(frame), 7'(e_frame));
            if (rst_seen) begin
                chk("rst_an", 7'(an), 7'h0F);
                chk("rst_seg", seg, 7'b1111111);
                chk("rst_dp", 7'(dp), 7'd1);
                chk("rst_frame", 7'(frame), 7'd0);
            end else begin
                case (scen)
                    1: begin
                        if (k == 1 || k == 33) chk("s1_frame", 7'(frame), 7'd1);
                        if (k >= 3 && k <= 8) begin
                            chk("s1_d0_an", 7'(an), 7'b0001110); chk("s1_d0_seg", seg, 7'b0110000);
                        end
                        if (k >= 11 && k <= 16) begin
                            chk("s1_d1_an", 7'(an), 7'b0001101); chk("s1_d1_seg", seg, 7'b0001000);
                        end
                        if (k >= 19 && k <= 24) begin
                            chk("s1_d2_an", 7'(an), 7'b0001011); chk("s1_d2_seg", seg, 7'b1111000);
                        end
                        if (k >= 25 && k <= 32) chk("s1_d3_an", 7'(an), 7'b0001111);
                        if (k >= 1 && (k - 1) % RD < BC) chk("s1_blank_an", 7'(an), 7'b0001111);
                    end
                    2: begin
                        if (k >= 3 && k <= 8) chk("s2_old_seg", seg, 7'b0110000);
                        if (k >= 35 && k <= 40) begin
                            chk("s2_new_an", 7'(an), 7'b0001110); chk("s2_new_seg", seg, 7'b0010010);
                        end
                    end
                    3: begin
                        if (k == 33) chk("s3_frame_hold", 7'(frame), 7'd1);
                        if (k >= 43 && k <= 48) begin
                            chk("s3_held_an", 7'(an), 7'b0001101); chk("s3_held_seg", seg, 7'b0001000);
                        end
                        if (k >= 75 && k <= 80) chk("s3_upd_seg", seg, 7'b1000000);
                    end
                    4: begin
                        if (k >= 3 && k <= 8) chk("s4_reload_seg", seg, 7'b1111001);
                        if (k >= 19 && k <= 24) chk("s4_reload_d2", seg, 7'b0011001);
                    end
                    5: begin
                        if (k >= 3 && k <= 8) chk("s5_d0_seg", seg, 7'b1000000);
                        if (k >= 11 && k <= 16) begin
                            chk("s5_d1_an", 7'(an), 7'b0001101);
                            chk("s5_d1_seg", seg, LZ ? 7'b1111111 : 7'b1000000);
                        end
                        if (k >= 19 && k <= 24) begin
                            chk("s5_d2_an", 7'(an), 7'b0001011);
                            chk("s5_d2_seg", seg, LZ ? 7'b1111111 : 7'b1000000);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic do_reset(input int n, input int s);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        scen  = s;
        reset = 1'b0;
    endtask

    task automatic go_to(input int c);
        while (k < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        r0 = 4'h3; r1 = 4'hA; r2 = 4'h7; hold = 1'b0;
        do_reset(3, 1);
        go_to(40);

        do_reset(2, 2);
        go_to(12);
        r0 = 4'h5;
        go_to(42);

        r0 = 4'h3;
        do_reset(2, 3);
        go_to(20);
        hold = 1'b1; r1 = 4'h0;
        go_to(40);
        hold = 1'b0;
        go_to(82);

        r0 = 4'h3; r1 = 4'hA; r2 = 4'h7;
        do_reset(2, 40);
        go_to(18);
        r0 = 4'h1; r1 = 4'h2; r2 = 4'h4;
        go_to(20);
        do_reset(1, 4);
        go_to(26);

        r0 = 4'h0; r1 = 4'h0; r2 = 4'h0;
        do_reset(2, 5);
        go_to(26);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
